// File: rtl/bitwise_lu_seq.sv
// Sequential bitwise logic unit: applies one of eight logic ops to WIDTH-bit operands
// CHUNK bits per cycle, with zero/parity flags. Optional popcount output via LU_POPCNT_EN.
module bitwise_lu_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
`ifdef LU_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a producer holds its data until the transfer.
  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_y;
  logic             r_nz;
  logic             r_zero;
  logic             r_par;
  logic             w_accept;
  logic             w_last;
  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_chunk;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = BUSY;
      BUSY:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    dbg_state = r_state;
  end

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_base    = int'(r_idx) * CHUNK;
  assign w_a_chunk = r_a[w_base +: CHUNK];
  assign w_b_chunk = r_b[w_base +: CHUNK];

  always_comb begin
    w_chunk = '0;
    case (r_op)
      3'b000: w_chunk = w_a_chunk & w_b_chunk;
      3'b001: w_chunk = w_a_chunk | w_b_chunk;
      3'b010: w_chunk = w_a_chunk ^ w_b_chunk;
      3'b011: w_chunk = ~(w_a_chunk & w_b_chunk);
      3'b100: w_chunk = ~(w_a_chunk | w_b_chunk);
      3'b101: w_chunk = ~(w_a_chunk ^ w_b_chunk);
      3'b110: w_chunk = w_a_chunk;
      default: w_chunk = ~w_a_chunk;
    endcase
  end

  // zero is registered only on the last chunk so it holds its value after DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_idx  <= '0;
      r_y    <= '0;
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
      r_par  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_idx  <= '0;
      r_y    <= '0;
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
      r_par  <= 1'b0;
    end else if (r_state == BUSY) begin
      r_y[w_base +: CHUNK] <= w_chunk;
      r_nz  <= r_nz | (|w_chunk);
      r_par <= r_par ^ (^w_chunk);
      if (w_last) r_zero <= ~(r_nz | (|w_chunk));
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign y      = r_y;
  assign zero   = r_zero;
  assign parity = r_par;

`ifdef LU_POPCNT_EN
  localparam int PC_W = $clog2(WIDTH + 1);
  logic [PC_W-1:0] r_popcnt;
  logic [PC_W-1:0] w_chunk_pc;

  always_comb begin
    w_chunk_pc = '0;
    for (int i = 0; i < CHUNK; i++) w_chunk_pc = w_chunk_pc + PC_W'(w_chunk[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 r_popcnt <= '0;
    else if (w_accept)          r_popcnt <= '0;
    else if (r_state == BUSY)   r_popcnt <= r_popcnt + w_chunk_pc;
  end

  assign popcnt = r_popcnt;
`endif

endmodule

// File: tb/tb_bitwise_lu_seq.sv
// Bench for bitwise_lu_seq: 64/16 instance plus a single-chunk 8/8 instance,
// expected results queued at issue and compared when out_valid rises.
module tb_bitwise_lu_seq;

  localparam int W  = 64;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    dbg_state;
  logic [W-1:0]  y;
  logic          zero;
  logic          parity;

  logic          rst8_n = 1'b0;
  logic          in8_valid = 1'b0;
  logic          in8_ready;
  logic [2:0]    op8 = 3'd0;
  logic [7:0]    a8 = '0;
  logic [7:0]    b8 = '0;
  logic          out8_valid;
  logic          out8_ready = 1'b0;
  logic [1:0]    dbg8_state;
  logic [7:0]    y8;
  logic          zero8;
  logic          parity8;

  int pc64;
  int pc8;

`ifdef LU_POPCNT_EN
  logic [6:0] popcnt;
  logic [3:0] popcnt8;
  always_comb begin
    pc64 = int'(popcnt);
    pc8  = int'(popcnt8);
  end
`else
  always_comb begin
    pc64 = 0;
    pc8  = 0;
  end
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  bitwise_lu_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state),
    .y(y), .zero(zero), .parity(parity)
`ifdef LU_POPCNT_EN
    , .popcnt(popcnt)
`endif
  );

  bitwise_lu_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in8_valid), .in_ready(in8_ready), .op(op8),
    .a(a8), .b(b8), .out_valid(out8_valid), .out_ready(out8_ready), .dbg_state(dbg8_state),
    .y(y8), .zero(zero8), .parity(parity8)
`ifdef LU_POPCNT_EN
    , .popcnt(popcnt8)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [2:0] o, input logic [W-1:0] va, vb);
    case (o)
      3'd0: return va & vb;
      3'd1: return va | vb;
      3'd2: return va ^ vb;
      3'd3: return ~(va & vb);
      3'd4: return ~(va | vb);
      3'd5: return ~(va ^ vb);
      3'd6: return va;
      default: return ~va;
    endcase
  endfunction

  task automatic pop_check(input string tag, input logic [W-1:0] gy, input logic gz, input logic gp,
                           input int gpc);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_y"}, gy, e);
    check({tag, "_zero"}, 64'(gz), 64'(e == '0));
    check({tag, "_parity"}, 64'(gp), 64'(^e));
`ifdef LU_POPCNT_EN
    check({tag, "_popcnt"}, 64'(gpc), 64'($countones(e)));
`else
    if (gpc != 0) check({tag, "_popcnt"}, 64'(gpc), 64'd0);
`endif
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] ey);
    int n;
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ey);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    check("busy_state", 64'(dbg_state), 64'd1);
  endtask

  task automatic wait_result(input bit scramble);
    int lat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (scramble) begin
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
      end
    end
    check("latency", 64'(lat), 64'(NC));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] ey);
    send(o, va, vb, ey);
    wait_result(1'b0);
    pop_check(tag, y, zero, parity, pc64);
    release_result();
  endtask

  task automatic run_op8(input string tag, input logic [2:0] o, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] ey);
    int lat;
    @(negedge clk);
    op8 = o; a8 = va; b8 = vb; in8_valid = 1'b1;
    check({tag, "_ready"}, 64'(in8_ready), 64'd1);
    @(posedge clk); #1;
    in8_valid = 1'b0;
    exp_q.push_back(64'(ey));
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out8_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd1);
    pop_check(tag, 64'(y8), zero8, parity8, pc8);
    out8_ready = 1'b1;
    @(posedge clk); #1;
    out8_ready = 1'b0;
    check({tag, "_idle"}, 64'(in8_ready), 64'd1);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb, held_y;
    logic         held_z, held_p;
    int           pulses;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", y, 64'd0);
    check("rst_flags", 64'({zero, parity}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_popcnt", 64'(pc64), 64'd0);
    check("rst8_y", 64'(y8), 64'd0);
    check("rst8_ready", 64'(in8_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("xor_plan", 3'd2, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h1DD99DD11DD99DD1);
    run_op("xor_ones", 3'd2, '1, '1, 64'h0);
    run_op("and_disjoint", 3'd0, 64'h0F, 64'hF0, 64'h0);
    run_op("or_disjoint", 3'd1, 64'h0F, 64'hF0, 64'hFF);
    run_op("nand_zero", 3'd3, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    run_op("not_a", 3'd7, 64'h1, 64'hDEADBEEF, 64'hFFFFFFFFFFFFFFFE);
    run_op("pass_a", 3'd6, 64'h8000000000000001, 64'hFFFF, 64'h8000000000000001);

    for (int k = 0; k < 8; k++) begin
      ro = 3'(k);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op("rand_op", ro, ra, rb, model_op(ro, ra, rb));
    end

    // Operand changes after acceptance must not leak into the result.
    send(3'd5, 64'hA5A5A5A5_0000FFFF, 64'h5A5A5A5A_00FF00FF, model_op(3'd5, 64'hA5A5A5A5_0000FFFF, 64'h5A5A5A5A_00FF00FF));
    wait_result(1'b1);
    pop_check("capture", y, zero, parity, pc64);
    release_result();

    send(3'd1, 64'h0F, 64'hF0, 64'hFF);
    wait_result(1'b0);
    held_y = y; held_z = zero; held_p = parity;
    @(negedge clk);
    op = 3'd2; a = 64'h1111; b = 64'h2222; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_y_stable", y, held_y);
      check("bp_flags_stable", 64'({zero, parity}), 64'({held_z, held_p}));
    end
    pop_check("bp_result", y, zero, parity, pc64);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_y_held_idle", y, held_y);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(64'h3333);
    check("bp_new_accepted", 64'(in_ready), 64'd0);
    wait_result(1'b0);
    pop_check("bp_new", y, zero, parity, pc64);
    release_result();

    send(3'd2, 64'hFFFF, 64'h1, 64'hFFFE);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_y", y, 64'd0);
    check("abort_flags", 64'({zero, parity}), 64'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);

    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; a = '1; b = '1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_wins_ready", 64'(in_ready), 64'd1);
    check("rst_wins_state", 64'(dbg_state), 64'd0);
    run_op("after_abort", 3'd4, 64'hF0F0, 64'h0F0F, ~64'hFFFF);

    @(negedge clk);
    rst8_n = 1'b1;
    run_op8("w8_xor", 3'd2, 8'h5A, 8'h0F, 8'h55);
    run_op8("w8_not", 3'd7, 8'h01, 8'hAA, 8'hFE);
    run_op8("w8_and0", 3'd0, 8'h0F, 8'hF0, 8'h00);
    @(negedge clk);
    op8 = 3'd1; a8 = 8'h01; b8 = 8'h02; in8_valid = 1'b1;
    @(posedge clk); #1;
    in8_valid = 1'b0;
    rst8_n = 1'b0;
    @(posedge clk); #1;
    rst8_n = 1'b1;
    check("w8_abort_ready", 64'(in8_ready), 64'd1);
    check("w8_abort_valid", 64'(out8_valid), 64'd0);
    check("w8_abort_y", 64'(y8), 64'd0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out8_valid) pulses++;
    end
    check("w8_abort_no_pulse", 64'(pulses), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
